// File: rtl/dmem_ctrl.sv
// RV32/RV64 data memory with a valid/ready request port and a stallable response pipeline.
// Loads are sized and extended, stores are byte-strobed, and illegal accesses return an error response.
module dmem_ctrl #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned OffW     = $clog2(NumBytes);
  localparam int unsigned IdxW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic                  stg_valid_q [READ_LATENCY];
  logic [DATA_WIDTH-1:0] stg_data_q  [READ_LATENCY];
  logic                  stg_err_q   [READ_LATENCY];

  logic                  advance;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [IdxW-1:0]       mem_idx;
  logic [OffW-1:0]       off;
  logic                  illegal;
  logic                  misaligned;
  logic                  in_range;
  logic                  req_err;
  logic [NumBytes-1:0]   strb_base;
  logic [NumBytes-1:0]   strb;
  logic [DATA_WIDTH-1:0] wdata_sh;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_sh;
  logic [DATA_WIDTH-1:0] mask;
  logic                  sbit;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] rsp_d;
  logic                  mem_we;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance   = !stg_valid_q[READ_LATENCY-1] || rsp_ready;
  assign req_ready = advance && !rst;
  assign accept    = req_valid && req_ready;

  assign word_idx = req_addr >> OffW;
  assign mem_idx  = word_idx[IdxW-1:0];
  assign off      = req_addr[OffW-1:0];
  assign in_range = word_idx < ADDR_WIDTH'(DEPTH_WORDS);

  always_comb begin
    illegal    = (req_size == 2'd3) && (DATA_WIDTH == 32);
    misaligned = 1'b0;
    strb_base  = '1;
    unique case (req_size)
      2'd0: begin misaligned = 1'b0;           strb_base = NumBytes'(1);  end
      2'd1: begin misaligned = req_addr[0];    strb_base = NumBytes'(3);  end
      2'd2: begin misaligned = |req_addr[1:0]; strb_base = NumBytes'(15); end
      2'd3: begin misaligned = |req_addr[2:0]; strb_base = '1;            end
    endcase
    req_err = illegal || misaligned || !in_range;
  end

  assign strb     = strb_base << off;
  assign wdata_sh = req_wdata << {off, 3'b000};
  assign rd_word  = mem[mem_idx];
  assign rd_sh    = rd_word >> {off, 3'b000};

  // Mask off the accessed bytes, then fill the upper bits with the sign when signed.
  always_comb begin
    mask = '1;
    sbit = 1'b0;
    unique case (req_size)
      2'd0: begin mask = DATA_WIDTH'(64'h0000_0000_0000_00ff); sbit = rd_sh[7];  end
      2'd1: begin mask = DATA_WIDTH'(64'h0000_0000_0000_ffff); sbit = rd_sh[15]; end
      2'd2: begin mask = DATA_WIDTH'(64'h0000_0000_ffff_ffff); sbit = rd_sh[31]; end
      2'd3: begin mask = '1;                                    sbit = 1'b0;      end
    endcase
    load_data = rd_sh & mask;
    if (sbit && !req_unsigned) begin
      load_data = load_data | ~mask;
    end
  end

  assign rsp_d  = (req_we || req_err) ? '0 : load_data;
  assign mem_we = accept && req_we && !req_err;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < NumBytes; b++) begin
        if (strb[b]) begin
          mem[mem_idx][b*8 +: 8] <= wdata_sh[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        stg_valid_q[i] <= 1'b0;
        stg_data_q[i]  <= '0;
        stg_err_q[i]   <= 1'b0;
      end
    end else if (advance) begin
      stg_valid_q[0] <= accept;
      stg_data_q[0]  <= rsp_d;
      stg_err_q[0]   <= accept && req_err;
      for (int i = 1; i < READ_LATENCY; i++) begin
        stg_valid_q[i] <= stg_valid_q[i-1];
        stg_data_q[i]  <= stg_data_q[i-1];
        stg_err_q[i]   <= stg_err_q[i-1];
      end
    end
  end

  assign rsp_valid = stg_valid_q[READ_LATENCY-1];
  assign rsp_rdata = stg_data_q[READ_LATENCY-1];
  assign rsp_err   = stg_err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench: a 32-bit, 3-stage instance for the main checks plus four 64-bit instances
// with latencies 1..4 for the wide round-trip and sign-extension checks.
module tb_dmem_ctrl;

  localparam int Lat = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        w_req_valid, w_req_we, w_req_unsigned, w_rsp_ready;
  logic [31:0] w_req_addr;
  logic [1:0]  w_req_size;
  logic [63:0] w_req_wdata;
  logic        w_req_ready [4];
  logic        w_rsp_valid [4];
  logic        w_rsp_err   [4];
  logic [63:0] w_rsp_rdata [4];

  int          w_lat [4];
  logic [63:0] w_dat [4];
  logic        w_err [4];
  logic        w_ready_ok;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(1024), .READ_LATENCY(Lat)
  ) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  for (genvar g = 0; g < 4; g++) begin : g_wide
    dmem_ctrl #(
      .ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH_WORDS(256), .READ_LATENCY(g + 1)
    ) u_wide (
      .clk(clk), .rst(rst), .req_valid(w_req_valid), .req_ready(w_req_ready[g]),
      .req_we(w_req_we), .req_addr(w_req_addr), .req_size(w_req_size),
      .req_unsigned(w_req_unsigned), .req_wdata(w_req_wdata), .rsp_valid(w_rsp_valid[g]),
      .rsp_ready(w_rsp_ready), .rsp_rdata(w_rsp_rdata[g]), .rsp_err(w_rsp_err[g])
    );
  end

  // One request on the main DUT; returns the first response and its latency in cycles.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata;
    n = 0;
    #1;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    lat = -1; rdata = 'x; err = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) req_valid = 1'b0;
      #1;
      if (rsp_valid) begin
        lat = c; rdata = rsp_rdata; err = rsp_err;
        break;
      end
    end
  endtask

  task automatic wide_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                          input logic uns, input logic [63:0] wdata);
    @(negedge clk);
    w_req_valid = 1'b1; w_req_we = we; w_req_addr = addr; w_req_size = size;
    w_req_unsigned = uns; w_req_wdata = wdata;
    #1;
    w_ready_ok = w_req_ready[0] & w_req_ready[1] & w_req_ready[2] & w_req_ready[3];
    for (int k = 0; k < 4; k++) begin
      w_lat[k] = -1; w_dat[k] = 'x; w_err[k] = 1'bx;
    end
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) w_req_valid = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
        if (w_lat[k] < 0 && w_rsp_valid[k]) begin
          w_lat[k] = c; w_dat[k] = w_rsp_rdata[k]; w_err[k] = w_rsp_err[k];
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", rsp_valid); end
    checks++;
    if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h exp 0", rsp_rdata); end
    checks++;
    if (rsp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", rsp_err); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", req_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, d, e, l);
    checks++;
    if (e !== 1'b0 || d !== 32'h0) begin
      errors++; $display("FAIL sw_rsp: got err=%b data=%h exp err=0 data=0", e, d);
    end
    checks++;
    if (l != Lat) begin errors++; $display("FAIL sw_latency: got %0d exp %0d", l, Lat); end
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, d, e, l);
    checks++;
    if (e !== 1'b0 || d !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got err=%b data=%h exp err=0 data=deadbeef", e, d);
    end
    checks++;
    if (l != Lat) begin errors++; $display("FAIL lw_latency: got %0d exp %0d", l, Lat); end
  endtask

  task automatic test_byte_half();
    logic [31:0] d; logic e; int l;
    logic [31:0] exp_d [6];
    logic [31:0] addr  [6];
    logic [1:0]  size  [6];
    logic        uns   [6];
    do_req(1'b1, 32'h11, 2'd0, 1'b0, 32'hFFFFFF80, d, e, l);
    checks++;
    if (e !== 1'b0) begin errors++; $display("FAIL sb_err: got %b exp 0", e); end
    addr[0] = 32'h11; size[0] = 2'd0; uns[0] = 1'b0; exp_d[0] = 32'hFFFFFF80;
    addr[1] = 32'h11; size[1] = 2'd0; uns[1] = 1'b1; exp_d[1] = 32'h00000080;
    addr[2] = 32'h10; size[2] = 2'd2; uns[2] = 1'b0; exp_d[2] = 32'hDEAD80EF;
    addr[3] = 32'h12; size[3] = 2'd1; uns[3] = 1'b0; exp_d[3] = 32'hFFFFDEAD;
    addr[4] = 32'h12; size[4] = 2'd1; uns[4] = 1'b1; exp_d[4] = 32'h0000DEAD;
    addr[5] = 32'h10; size[5] = 2'd1; uns[5] = 1'b0; exp_d[5] = 32'hFFFF80EF;
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, addr[i], size[i], uns[i], 32'h0, d, e, l);
      checks++;
      if (e !== 1'b0 || d !== exp_d[i]) begin
        errors++;
        $display("FAIL load_%0d: got err=%b data=%h exp err=0 data=%h", i, e, d, exp_d[i]);
      end
    end
    do_req(1'b1, 32'h12, 2'd1, 1'b0, 32'hAAAA1234, d, e, l);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, d, e, l);
    checks++;
    if (d !== 32'h123480EF) begin errors++; $display("FAIL sh_merge: got %h exp 123480ef", d); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int l;
    do_req(1'b1, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, d, e, l);
    do_req(1'b1, 32'h18, 2'd2, 1'b0, 32'h11111111, d, e, l);
    do_req(1'b0, 32'h13, 2'd1, 1'b0, 32'h0, d, e, l);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL lh_misaligned: got err=%b data=%h exp err=1 data=0", e, d);
    end
    do_req(1'b1, 32'h1000, 2'd2, 1'b0, 32'h12345678, d, e, l);
    checks++;
    if (e !== 1'b1 || l != Lat) begin
      errors++; $display("FAIL sw_range: got err=%b lat=%0d exp err=1 lat=%0d", e, l, Lat);
    end
    do_req(1'b0, 32'h0, 2'd2, 1'b0, 32'h0, d, e, l);
    checks++;
    if (d !== 32'hCAFEF00D) begin errors++; $display("FAIL range_no_write: got %h exp cafef00d", d); end
    do_req(1'b1, 32'h18, 2'd3, 1'b0, 32'h22222222, d, e, l);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL size3_err: got %b exp 1", e); end
    do_req(1'b1, 32'h1A, 2'd2, 1'b0, 32'h33333333, d, e, l);
    checks++;
    if (e !== 1'b1) begin errors++; $display("FAIL sw_misaligned: got %b exp 1", e); end
    do_req(1'b0, 32'h18, 2'd2, 1'b0, 32'h0, d, e, l);
    checks++;
    if (d !== 32'h11111111) begin errors++; $display("FAIL err_no_write: got %h exp 11111111", d); end
    do_req(1'b1, 32'hFFC, 2'd2, 1'b0, 32'hA5A5A5A5, d, e, l);
    do_req(1'b0, 32'hFFC, 2'd2, 1'b0, 32'h0, d, e, l);
    checks++;
    if (e !== 1'b0 || d !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL last_word: got err=%b data=%h exp err=0 data=a5a5a5a5", e, d);
    end
    do_req(1'b0, 32'h1000, 2'd0, 1'b1, 32'h0, d, e, l);
    checks++;
    if (e !== 1'b1 || d !== 32'h0) begin
      errors++; $display("FAIL lbu_range: got err=%b data=%h exp err=1 data=0", e, d);
    end
  endtask

  task automatic test_stall();
    logic [31:0] d; logic e; int l;
    logic [31:0] exp_d [8];
    logic [31:0] got [$];
    int issued, hold_bad;
    bit saw_block, have_held;
    logic [31:0] held;
    for (int i = 0; i < 8; i++) begin
      exp_d[i] = 32'hA0000000 | (32'(i) * 32'h00010111);
      do_req(1'b1, 32'h20 + 32'(i * 4), 2'd2, 1'b0, exp_d[i], d, e, l);
    end
    issued = 0; hold_bad = 0; saw_block = 0; have_held = 0; held = '0;
    for (int cyc = 0; cyc < 60 && got.size() < 8; cyc++) begin
      @(negedge clk);
      rsp_ready = !(cyc >= 4 && cyc < 9);
      if (issued < 8) begin
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h20 + 32'(issued * 4);
        req_size = 2'd2; req_unsigned = 1'b0;
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (!rsp_ready && rsp_valid) begin
        if (have_held && rsp_rdata !== held) hold_bad++;
        held = rsp_rdata; have_held = 1;
      end
      if (req_valid && !req_ready) saw_block = 1;
      if (rsp_valid && rsp_ready) got.push_back(rsp_rdata);
      if (req_valid && req_ready) issued++;
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL stall_count: got %0d exp 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      if (i < got.size()) begin
        checks++;
        if (got[i] !== exp_d[i]) begin
          errors++; $display("FAIL stall_order_%0d: got %h exp %h", i, got[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (!saw_block) begin errors++; $display("FAIL stall_ready_low: got 0 exp 1"); end
    checks++;
    if (hold_bad != 0) begin errors++; $display("FAIL stall_hold: got %0d changes exp 0", hold_bad); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int l;
    int spurious;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h44; req_size = 2'd2;
    req_unsigned = 1'b0; req_wdata = 32'h5A5A5A5A;
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'h40;
    @(negedge clk);
    req_valid = 1'b0; rst = 1'b1;
    spurious = 0;
    for (int c = 0; c < 10; c++) begin
      if (c == 2) rst = 1'b0;
      #1;
      if (rsp_valid) spurious++;
      @(negedge clk);
    end
    checks++;
    if (spurious != 0) begin errors++; $display("FAIL reset_drop: got %0d rsp exp 0", spurious); end
    do_req(1'b0, 32'h44, 2'd2, 1'b0, 32'h0, d, e, l);
    checks++;
    if (d !== 32'h5A5A5A5A || l != Lat) begin
      errors++; $display("FAIL reset_store_kept: got %h lat=%0d exp 5a5a5a5a lat=%0d", d, l, Lat);
    end
  endtask

  task automatic test_wide();
    logic [31:0] addr  [6];
    logic [1:0]  size  [6];
    logic        uns   [6];
    logic [63:0] exp_d [6];
    logic        exp_e [6];
    wide_req(1'b1, 32'h8, 2'd3, 1'b0, 64'h0123456789ABCDEF);
    checks++;
    if (!w_ready_ok) begin errors++; $display("FAIL wide_ready: got 0 exp 1"); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (w_lat[k] != k + 1 || w_err[k] !== 1'b0) begin
        errors++;
        $display("FAIL wide_sd_L%0d: got lat=%0d err=%b exp lat=%0d err=0", k + 1, w_lat[k],
                 w_err[k], k + 1);
      end
    end
    wide_req(1'b1, 32'h10, 2'd3, 1'b0, 64'hFEDCBA9876543210);
    addr[0] = 32'h8;   size[0] = 2'd3; uns[0] = 1'b0; exp_d[0] = 64'h0123456789ABCDEF; exp_e[0] = 0;
    addr[1] = 32'h14;  size[1] = 2'd2; uns[1] = 1'b0; exp_d[1] = 64'hFFFFFFFFFEDCBA98; exp_e[1] = 0;
    addr[2] = 32'h14;  size[2] = 2'd2; uns[2] = 1'b1; exp_d[2] = 64'h00000000FEDCBA98; exp_e[2] = 0;
    addr[3] = 32'hC;   size[3] = 2'd2; uns[3] = 1'b0; exp_d[3] = 64'h0000000001234567; exp_e[3] = 0;
    addr[4] = 32'h14;  size[4] = 2'd3; uns[4] = 1'b0; exp_d[4] = 64'h0;                exp_e[4] = 1;
    addr[5] = 32'h800; size[5] = 2'd3; uns[5] = 1'b0; exp_d[5] = 64'h0;                exp_e[5] = 1;
    for (int i = 0; i < 6; i++) begin
      wide_req(1'b0, addr[i], size[i], uns[i], 64'h0);
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (w_lat[k] != k + 1 || w_err[k] !== exp_e[i] || w_dat[k] !== exp_d[i]) begin
          errors++;
          $display("FAIL wide_load_%0d_L%0d: got lat=%0d err=%b data=%h exp lat=%0d err=%b data=%h",
                   i, k + 1, w_lat[k], w_err[k], w_dat[k], k + 1, exp_e[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0;
    req_unsigned = 1'b0; req_wdata = '0; rsp_ready = 1'b1;
    w_req_valid = 1'b0; w_req_we = 1'b0; w_req_addr = '0; w_req_size = '0;
    w_req_unsigned = 1'b0; w_req_wdata = '0; w_rsp_ready = 1'b1; w_ready_ok = 1'b0;
    test_reset();
    test_word();
    test_byte_half();
    test_errors();
    test_stall();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "timeout");
  end

endmodule
